dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two back-end requesters (lane 0 and lane 1 load/store ops coming out of retire).
- Arbitrates round-robin, issues one registered memory access per grant, and tracks one outstanding load.
- Matches each load to its memory response and returns data with the requester's ROB tag.
- Flushed on a mispredicted branch.

---
 rtl/dmem_arbiter_if.sv | 58 +++++
 rtl/dmem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the dmem_arbiter request, response and memory-port signals.
//   slave  : arbiter side (takes requests/flush/read data, drives grants/responses/memory strobes)
//   master : environment side (requesters, branch unit and data memory)
// Request lanes : reqN_valid/ready/wr_en/addr/data/tag, N = 0, 1
// Response      : rsp_valid/port/tag/data, err
// Memory port   : dmem_wr_en/rd_en/addr/data_out out, dmem_valid_in/valid_addr_in/data_in back
interface dmem_arbiter_if #(
  parameter int unsigned AW    = 10,
  parameter int unsigned TAG_W = 5
);
  logic             flush;
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_wr_en;
  logic [31:0]      req0_addr;
  logic [31:0]      req0_data;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_wr_en;
  logic [31:0]      req1_addr;
  logic [31:0]      req1_data;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp_valid;
  logic             rsp_port;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;
  logic             err;
  logic [3:0]       dmem_wr_en;
  logic             dmem_rd_en;
  logic [31:0]      dmem_addr;
  logic [31:0]      dmem_data_out;
  logic             dmem_valid_in;
  logic [AW-1:0]    dmem_valid_addr_in;
  logic [31:0]      dmem_data_in;

  modport slave (
    input  flush,
    input  req0_valid, req0_wr_en, req0_addr, req0_data, req0_tag,
    output req0_ready,
    input  req1_valid, req1_wr_en, req1_addr, req1_data, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_port, rsp_tag, rsp_data, err,
    output dmem_wr_en, dmem_rd_en, dmem_addr, dmem_data_out,
    input  dmem_valid_in, dmem_valid_addr_in, dmem_data_in
  );

  modport master (
    output flush,
    output req0_valid, req0_wr_en, req0_addr, req0_data, req0_tag,
    input  req0_ready,
    output req1_valid, req1_wr_en, req1_addr, req1_data, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_port, rsp_tag, rsp_data, err,
    input  dmem_wr_en, dmem_rd_en, dmem_addr, dmem_data_out,
    output dmem_valid_in, dmem_valid_addr_in, dmem_data_in
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two retire lanes.
// Issues one registered access per grant, tracks a single outstanding load, and returns
// its data tagged with the requester's ROB tag. A flush kills any in-flight load.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_arbiter_if.slave (requests, grants, responses, memory port, flush)
// Optional: define DMEM_ARB_TIMEOUT_EN to abort a load after TIMEOUT cycles in WAIT_RD
// with an err pulse; otherwise the load waits indefinitely and err stays 0.
module dmem_arbiter #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [0:0] {StIdle, StWaitRd} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [3:0]       dmem_wr_en_q, dmem_wr_en_d;
  logic             dmem_rd_en_q, dmem_rd_en_d;
  logic [31:0]      dmem_addr_q, dmem_addr_d;
  logic [31:0]      dmem_data_q, dmem_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_port_q, rsp_port_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             err_q, err_d;
  logic             pend_port_q, pend_port_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;

  logic             grant0, grant1, xfer_port;
  logic [3:0]       sel_wr_en;
  logic [31:0]      sel_addr, sel_data;
  logic [TAG_W-1:0] sel_tag;
  logic             hit, timeout_hit;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle && !bus.flush) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
      grant1 = bus.req1_valid && (!bus.req0_valid || rr_q);
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign xfer_port = grant1;
  assign sel_wr_en = xfer_port ? bus.req1_wr_en : bus.req0_wr_en;
  assign sel_addr  = xfer_port ? bus.req1_addr  : bus.req0_addr;
  assign sel_data  = xfer_port ? bus.req1_data  : bus.req0_data;
  assign sel_tag   = xfer_port ? bus.req1_tag   : bus.req0_tag;

  // dmem_addr_q only changes on a grant, so it still holds the load address in WAIT_RD.
  assign hit = (state_q == StWaitRd) && bus.dmem_valid_in &&
               (bus.dmem_valid_addr_in == dmem_addr_q[AW-1:0]);

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == StWaitRd) && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (!bus.flush && state_q == StWaitRd && !hit && !timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    dmem_wr_en_d = 4'h0;
    dmem_rd_en_d = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_data_d  = dmem_data_q;
    rsp_valid_d  = 1'b0;
    rsp_port_d   = rsp_port_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_data_d   = rsp_data_q;
    err_d        = 1'b0;
    pend_port_d  = pend_port_q;
    pend_tag_d   = pend_tag_q;
    if (bus.flush) begin
      // Flush beats a same-cycle hit or timeout: the load simply vanishes.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant0 || grant1) begin
            rr_d         = ~xfer_port;
            dmem_wr_en_d = sel_wr_en;
            dmem_rd_en_d = (sel_wr_en == 4'h0);
            dmem_addr_d  = sel_addr;
            dmem_data_d  = sel_data;
            if (sel_wr_en != 4'h0) begin
              // Stores complete on issue.
              rsp_valid_d = 1'b1;
              rsp_port_d  = xfer_port;
              rsp_tag_d   = sel_tag;
              rsp_data_d  = 32'h0;
            end else begin
              state_d     = StWaitRd;
              pend_port_d = xfer_port;
              pend_tag_d  = sel_tag;
            end
          end
        end
        StWaitRd: begin
          if (hit) begin
            rsp_valid_d = 1'b1;
            rsp_port_d  = pend_port_q;
            rsp_tag_d   = pend_tag_q;
            rsp_data_d  = bus.dmem_data_in;
            state_d     = StIdle;
          end else if (timeout_hit) begin
            err_d      = 1'b1;
            rsp_port_d = pend_port_q;
            rsp_tag_d  = pend_tag_q;
            state_d    = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_q         <= 1'b0;
      dmem_wr_en_q <= 4'h0;
      dmem_rd_en_q <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_data_q  <= 32'h0;
      rsp_valid_q  <= 1'b0;
      rsp_port_q   <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_data_q   <= 32'h0;
      err_q        <= 1'b0;
      pend_port_q  <= 1'b0;
      pend_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      dmem_wr_en_q <= dmem_wr_en_d;
      dmem_rd_en_q <= dmem_rd_en_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_data_q  <= dmem_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_port_q   <= rsp_port_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
      pend_port_q  <= pend_port_d;
      pend_tag_q   <= pend_tag_d;
    end
  end

  assign bus.dmem_wr_en    = dmem_wr_en_q;
  assign bus.dmem_rd_en    = dmem_rd_en_q;
  assign bus.dmem_addr     = dmem_addr_q;
  assign bus.dmem_data_out = dmem_data_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_port      = rsp_port_q;
  assign bus.rsp_tag       = rsp_tag_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: load/response, alternating stores, busy blocking,
// flush behaviour, address mismatch and the optional load timeout (TIMEOUT = 8).
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(10), .TAG_W(5)) bus ();

  dmem_arbiter #(
    .MEM_DEPTH(1024),
    .TAG_W    (5),
    .TIMEOUT  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int lane, input logic v, input logic [3:0] we,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
    if (lane == 0) begin
      bus.req0_valid = v; bus.req0_wr_en = we; bus.req0_addr = a;
      bus.req0_data = d; bus.req0_tag = t;
    end else begin
      bus.req1_valid = v; bus.req1_wr_en = we; bus.req1_addr = a;
      bus.req1_data = d; bus.req1_tag = t;
    end
  endtask

  task automatic mem(input logic v, input logic [9:0] a, input logic [31:0] d);
    bus.dmem_valid_in = v; bus.dmem_valid_addr_in = a; bus.dmem_data_in = d;
  endtask

  initial begin
    bus.flush = 1'b0;
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    mem(1'b0, 10'h0, 32'h0);

    // Reset state (asynchronous, before any clock edge)
    #3;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_tag", bus.rsp_tag, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_dmem_rd", bus.dmem_rd_en, 0);
    chk("rst_dmem_wr", bus.dmem_wr_en, 0);
    chk("rst_dmem_addr", bus.dmem_addr, 0);
    tick();
    tick();
    rst = 1'b0;

    // Lane 0 load 0x10 tag 3; lane 1 store waits behind it; mismatching return first
    set_req(0, 1'b1, 4'h0, 32'h10, 32'h0, 5'd3);
    #1;
    chk("ld_ready0", bus.req0_ready, 1);
    chk("ld_ready1", bus.req1_ready, 0);
    tick();                                        // T+1
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    set_req(1, 1'b1, 4'hF, 32'h20, 32'h1111, 5'd7);
    #1;
    chk("ld_rd_en", bus.dmem_rd_en, 1);
    chk("ld_wr_en", bus.dmem_wr_en, 0);
    chk("ld_addr", bus.dmem_addr, 32'h10);
    chk("ld_busy_ready1_a", bus.req1_ready, 0);
    tick();                                        // T+2
    chk("ld_rd_pulse", bus.dmem_rd_en, 0);
    chk("ld_busy_ready1_b", bus.req1_ready, 0);
    mem(1'b1, 10'h14, 32'hDEADBEEF);
    tick();                                        // T+3
    chk("ld_mismatch_norsp", bus.rsp_valid, 0);
    chk("ld_busy_ready1_c", bus.req1_ready, 0);
    mem(1'b1, 10'h10, 32'hCAFEF00D);
    tick();                                        // T+4
    mem(1'b0, 10'h0, 32'h0);
    #1;
    chk("ld_rsp_valid", bus.rsp_valid, 1);
    chk("ld_rsp_port", bus.rsp_port, 0);
    chk("ld_rsp_tag", bus.rsp_tag, 3);
    chk("ld_rsp_data", bus.rsp_data, 32'hCAFEF00D);
    chk("ld_idle_ready1", bus.req1_ready, 1);
    tick();                                        // lane 1 store issued
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    chk("st1_wr_en", bus.dmem_wr_en, 4'hF);
    chk("st1_rd_en", bus.dmem_rd_en, 0);
    chk("st1_addr", bus.dmem_addr, 32'h20);
    chk("st1_data", bus.dmem_data_out, 32'h1111);
    chk("st1_rsp", {bus.rsp_valid, bus.rsp_port, bus.rsp_tag}, {1'b1, 1'b1, 5'd7});
    chk("st1_rsp_data", bus.rsp_data, 0);

    // Both lanes store every cycle for 4 cycles: grants 0,1,0,1 (rr back at 0)
    set_req(0, 1'b1, 4'h3, 32'h100, 32'hA0, 5'd1);
    set_req(1, 1'b1, 4'hC, 32'h200, 32'hB1, 5'd2);
    #1;
    chk("rr_c0_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
      end
      #1;
      chk("rr_wr_en", bus.dmem_wr_en, (i % 2 == 0) ? 4'h3 : 4'hC);
      chk("rr_addr", bus.dmem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_rsp", {bus.rsp_valid, bus.rsp_port, bus.rsp_tag},
          (i % 2 == 0) ? {1'b1, 1'b0, 5'd1} : {1'b1, 1'b1, 5'd2});
      chk("rr_rsp_data", bus.rsp_data, 0);
      if (i < 3) chk("rr_next_ready", {bus.req0_ready, bus.req1_ready},
                     (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    tick();
    chk("rr_done_rsp", bus.rsp_valid, 0);
    chk("rr_done_wr", bus.dmem_wr_en, 0);

    // Flush: same-cycle request not granted; outstanding load killed even with a hit
    set_req(0, 1'b1, 4'h0, 32'h40, 32'h0, 5'd4);
    bus.flush = 1'b1;
    #1;
    chk("fl_req_ready0", bus.req0_ready, 0);
    tick();
    chk("fl_no_issue", bus.dmem_rd_en, 0);
    bus.flush = 1'b0;
    #1;
    chk("fl_after_ready0", bus.req0_ready, 1);
    tick();                                        // load in WAIT_RD
    chk("fl_ld_rd", bus.dmem_rd_en, 1);
    chk("fl_ld_addr", bus.dmem_addr, 32'h40);
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    bus.flush = 1'b1;
    mem(1'b1, 10'h40, 32'h5555);                   // hit together with flush
    tick();
    bus.flush = 1'b0;
    mem(1'b1, 10'h40, 32'h9999);                   // late return while IDLE
    set_req(1, 1'b1, 4'h1, 32'h44, 32'h77, 5'd10);
    #1;
    chk("fl_norsp", bus.rsp_valid, 0);
    chk("fl_idle_ready1", bus.req1_ready, 1);
    tick();
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    mem(1'b0, 10'h0, 32'h0);
    bus.flush = 1'b1;                              // flush during store issue cycle
    #1;
    chk("fl_st_wr_kept", bus.dmem_wr_en, 4'h1);
    chk("fl_st_rsp", {bus.rsp_valid, bus.rsp_port, bus.rsp_tag}, {1'b1, 1'b1, 5'd10});
    chk("fl_st_data", bus.rsp_data, 0);
    tick();
    bus.flush = 1'b0;
    chk("fl_hold_valid", bus.rsp_valid, 0);
    chk("fl_hold_tag", bus.rsp_tag, 10);

    // Load with no response: timeout abort (or indefinite wait without the feature)
    set_req(0, 1'b1, 4'h0, 32'h80, 32'h0, 5'd21);
    #1;
    chk("to_ready0", bus.req0_ready, 1);
    tick();                                        // first WAIT_RD cycle
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    set_req(1, 1'b1, 4'h0, 32'h84, 32'h0, 5'd22);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_wait_err", bus.err, 0);
      chk("to_wait_ready1", bus.req1_ready, 0);
      tick();
    end
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
`ifdef DMEM_ARB_TIMEOUT_EN
    chk("to_err", bus.err, 1);
    chk("to_rsp_valid", bus.rsp_valid, 0);
    chk("to_tag", bus.rsp_tag, 21);
    chk("to_port", bus.rsp_port, 0);
    tick();
    chk("to_err_pulse", bus.err, 0);
`else
    chk("nto_err", bus.err, 0);
    chk("nto_rsp_valid", bus.rsp_valid, 0);
    set_req(1, 1'b1, 4'h0, 32'h84, 32'h0, 5'd22);
    #1;
    chk("nto_still_busy", bus.req1_ready, 0);
    tick();
    chk("nto_err_later", bus.err, 0);
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
